// File: rtl/pipe_ctrl_pkg.sv
// Shared defines for the pipeline controller: reset level, bus widths,
// stall encodings, exception codes and controller FSM state codes.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b1;
  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;

  localparam logic [RegBus-1:0] EXC_ERET = 32'h0000_000e;

  localparam logic [0:0] CTRL_NORMAL = 1'b0;
  localparam logic [0:0] CTRL_GUARD = 1'b1;

  function automatic logic [RegBus-1:0] sat_inc(
    input logic [RegBus-1:0] v
  );
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// MEM-stall watchdog: counts consecutive data-bus stall cycles and
// pulses o_fire when the run reaches LIMIT cycles.
module stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_flush,
  output logic o_fire
);

  localparam logic [15:0] LastCnt = 16'(LIMIT - 1);

  logic [15:0] r_run;
  logic        w_fire;

  assign w_fire = i_req && !i_flush && (r_run == LastCnt);
  assign o_fire = w_fire;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_run <= '0;
    end else if (!i_req || i_flush || w_fire) begin
      r_run <= '0;
    end else begin
      r_run <= r_run + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall/flush arbitration, post-flush guard
// and stall-cycle counter. Watchdog enabled by PIPE_CTRL_WDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [RegBus-1:0] EXC_VECTOR = 32'h0000_0020,
  parameter int GUARD_CYCLES = 2
`ifdef PIPE_CTRL_WDOG_EN
  ,
  parameter int WDOG_LIMIT = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              stallreq_from_mem,
  input  logic [RegBus-1:0] excepttype_i,
  input  logic [RegBus-1:0] cp0_epc_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [RegBus-1:0] new_pc,
  output logic [RegBus-1:0] stall_cnt,
  output logic              wdog_o
);

  localparam logic [3:0] GuardLoad = 4'(GUARD_CYCLES - 1);

  logic [0:0]        r_state;
  logic [3:0]        r_guard;
  logic [RegBus-1:0] r_stall_cnt;

  logic w_active;
  logic w_accept;
  logic w_mem;
  logic w_ex;
  logic w_id;

  assign w_active = (rst != RstEnable);
  assign w_accept = w_active && (r_state == CTRL_NORMAL)
                 && (excepttype_i != ZeroWord);

  // Mutually exclusive selects encode the priority order
  assign w_mem = w_active && !w_accept && stallreq_from_mem;
  assign w_ex = w_active && !w_accept && !stallreq_from_mem
             && stallreq_from_ex;
  assign w_id = w_active && !w_accept && !stallreq_from_mem
             && !stallreq_from_ex && stallreq_from_id;

  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    new_pc = ZeroWord;
    unique case (1'b1)
      w_accept: begin
        flush = 1'b1;
        new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      end
      w_mem: stall = STALL_MEM;
      w_ex: stall = STALL_EX;
      w_id: stall = STALL_ID;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= CTRL_NORMAL;
      r_guard <= '0;
      r_stall_cnt <= ZeroWord;
    end else begin
      case (r_state)
        CTRL_NORMAL: begin
          if (w_accept) begin
            r_state <= CTRL_GUARD;
            r_guard <= GuardLoad;
          end
        end
        CTRL_GUARD: begin
          if (r_guard == 4'd0) begin
            r_state <= CTRL_NORMAL;
          end else begin
            r_guard <= r_guard - 4'd1;
          end
        end
        default: r_state <= CTRL_NORMAL;
      endcase
      if (stall != STALL_NONE) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

`ifdef PIPE_CTRL_WDOG_EN
  logic w_fire;

  stall_wdog #(
    .LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .i_req  (stallreq_from_mem),
    .i_flush(flush),
    .o_fire (w_fire)
  );

  assign wdog_o = w_fire && w_active;
`else
  assign wdog_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random
// traffic against a cycle-indexed reference model.
module tb_pipe_ctrl;

  localparam int G = 2;
  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int LIM = 4;
`ifdef PIPE_CTRL_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sid, sex, smem;
  logic [31:0] exc, epc;
  logic [5:0] stall;
  logic flush, wdog;
  logic [31:0] new_pc, scnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR(VEC),
    .GUARD_CYCLES(G)
`ifdef PIPE_CTRL_WDOG_EN
    ,
    .WDOG_LIMIT(LIM)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (sid),
    .stallreq_from_ex (sex),
    .stallreq_from_mem(smem),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_cnt        (scnt),
    .wdog_o           (wdog)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: cycle index, cycle of last accepted exception,
  // current MEM-request run length, stall count.
  int cyc = 0;
  int last_acc = -1000;
  int run_len = 0;
  int e_run;
  logic [31:0] m_cnt = 32'd0;
  logic e_acc, e_flush, e_wdog;
  logic [5:0] e_stall;
  logic [31:0] e_pc;

  task automatic apply(input logic r, input logic i, input logic x,
                       input logic m, input logic [31:0] e,
                       input logic [31:0] p);
    @(negedge clk);
    rst = r; sid = i; sex = x; smem = m; exc = e; epc = p;
    #1;
    e_acc = !r && (e != 32'd0) && (cyc - last_acc > G);
    e_flush = e_acc;
    e_pc = e_acc ? ((e == 32'he) ? p : VEC) : 32'd0;
    if (r || e_acc) e_stall = 6'b000000;
    else if (m) e_stall = 6'b011111;
    else if (x) e_stall = 6'b001111;
    else if (i) e_stall = 6'b000111;
    else e_stall = 6'b000000;
    e_run = (r || e_acc || !m) ? 0 : run_len + 1;
    e_wdog = WD && (e_run != 0) && (e_run % LIM == 0);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      last_acc = -1000;
      m_cnt = 32'd0;
    end else begin
      if (e_acc) last_acc = cyc;
      if (e_stall != 6'd0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    run_len = e_run;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      apply(0, 0, 0, 0, 0, 0);
      advance();
    end
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 32'h8, 32'h55);
    n_chk++;
    if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_comb stall=%b flush=%b pc=%h want 0/0/0",
               stall, flush, new_pc);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (scnt !== 32'd0 || stall !== 6'd0 || flush !== 1'b0
        || wdog !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state cnt=%0d stall=%b flush=%b wdog=%b want 0",
               scnt, stall, flush, wdog);
    end
    advance();
  endtask

  task automatic test_priority();
    apply(0, 1, 0, 0, 0, 0);
    n_chk++;
    if (stall !== 6'b000111) begin
      n_fail++;
      $display("FAIL prio_id stall=%b want 000111", stall);
    end
    advance();
    apply(0, 1, 0, 1, 0, 0);
    n_chk++;
    if (stall !== 6'b011111) begin
      n_fail++;
      $display("FAIL prio_mem stall=%b want 011111", stall);
    end
    advance();
    apply(0, 0, 1, 0, 0, 0);
    n_chk++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL prio_ex stall=%b want 001111", stall);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (stall !== 6'd0 || scnt !== 32'd3) begin
      n_fail++;
      $display("FAIL prio_release stall=%b cnt=%0d want 0/3", stall, scnt);
    end
    advance();
  endtask

  task automatic test_exc_beats_stall();
    apply(0, 0, 1, 0, 32'h8, 32'h99);
    n_chk++;
    if (flush !== 1'b1 || stall !== 6'd0 || new_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL exc_win flush=%b stall=%b pc=%h want 1/0/20",
               flush, stall, new_pc);
    end
    advance();
    apply(0, 0, 0, 0, 32'h8, 32'h99);
    n_chk++;
    if (flush !== 1'b0 || new_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL exc_guard flush=%b pc=%h want 0/0", flush, new_pc);
    end
    advance();
    idle(3);
  endtask

  task automatic test_eret();
    apply(0, 0, 0, 0, 32'he, 32'h0000_1234);
    n_chk++;
    if (flush !== 1'b1 || new_pc !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL eret flush=%b pc=%h want 1/00001234", flush, new_pc);
    end
    advance();
    for (int k = 1; k <= 3; k++) begin
      apply(0, 0, 0, 0, 32'h8, 32'h0);
      n_chk++;
      if (flush !== (k == 3) || new_pc !== ((k == 3) ? VEC : 32'd0)) begin
        n_fail++;
        $display("FAIL eret_spacing k=%0d flush=%b pc=%h want %0d",
                 k, flush, new_pc, (k == 3));
      end
      advance();
    end
    idle(3);
  endtask

  task automatic test_reset_guard();
    apply(0, 1, 0, 0, 32'h8, 0);
    advance();
    apply(1, 1, 0, 0, 32'h8, 0);
    n_chk++;
    if (flush !== 1'b0 || stall !== 6'd0) begin
      n_fail++;
      $display("FAIL rstguard_comb flush=%b stall=%b want 0/0", flush, stall);
    end
    advance();
    apply(0, 0, 0, 0, 32'h8, 0);
    n_chk++;
    if (flush !== 1'b1 || scnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rstguard_accept flush=%b cnt=%0d want 1/0", flush, scnt);
    end
    advance();
    idle(3);
  endtask

  task automatic test_saturation();
    apply(0, 0, 0, 0, 0, 0);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    advance();
    #1 release dut.r_stall_cnt;
    for (int k = 0; k < 4; k++) begin
      apply(0, (k < 3), 0, 0, 0, 0);
      n_chk++;
      if (scnt !== ((k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF)) begin
        n_fail++;
        $display("FAIL sat k=%0d cnt=%h", k, scnt);
      end
      advance();
    end
  endtask

  task automatic test_wdog();
    for (int k = 1; k <= 9; k++) begin
      apply(0, 0, 0, (k <= 8), 0, 0);
      n_chk++;
      if (wdog !== (WD && (k == 4 || k == 8))
          || stall !== ((k <= 8) ? 6'b011111 : 6'd0)) begin
        n_fail++;
        $display("FAIL wdog k=%0d wdog=%b stall=%b", k, wdog, stall);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    int sel;
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 7);
      e = (sel < 4) ? 32'd0 : (sel == 4) ? 32'h8
        : (sel == 5) ? 32'he : $urandom;
      apply(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 2) != 0), e, $urandom);
      n_chk++;
      if (stall !== e_stall || flush !== e_flush || new_pc !== e_pc
          || wdog !== e_wdog || scnt !== m_cnt) begin
        n_fail++;
        $display("FAIL rand k=%0d stall=%b/%b flush=%b/%b pc=%h/%h wdog=%b/%b cnt=%0d/%0d",
                 k, stall, e_stall, flush, e_flush, new_pc, e_pc,
                 wdog, e_wdog, scnt, m_cnt);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; sid = 0; sex = 0; smem = 0; exc = 0; epc = 0;
    test_reset();
    test_priority();
    test_exc_beats_stall();
    test_eret();
    test_reset_guard();
    test_saturation();
    test_wdog();
    apply(1, 0, 0, 0, 0, 0);
    advance();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
